// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, standard mode timing sets and helper functions
// for the parametrised VGA raster engine.
package vga_pkg;

   // Colour layout: three channels packed {R,G,B}.
   localparam int RGB_CHANNELS    = 3;
   localparam int DEFAULT_COLOR_W = 4;
   localparam int PATTERN_BARS    = 8;

   typedef struct packed {
      logic [DEFAULT_COLOR_W-1:0] r;
      logic [DEFAULT_COLOR_W-1:0] g;
      logic [DEFAULT_COLOR_W-1:0] b;
   } rgb_def_t;

   // 640x480@60, 25.175 MHz nominal pixel clock (25 MHz in practice).
   localparam int M640_H_ACTIVE = 640;
   localparam int M640_H_FP     = 16;
   localparam int M640_H_SYNC   = 96;
   localparam int M640_H_BP     = 48;
   localparam int M640_V_ACTIVE = 480;
   localparam int M640_V_FP     = 10;
   localparam int M640_V_SYNC   = 2;
   localparam int M640_V_BP     = 33;
   localparam int M640_HS_POL   = 0;
   localparam int M640_VS_POL   = 0;

   // 800x600@60, 40 MHz pixel clock, positive syncs.
   localparam int M800_H_ACTIVE = 800;
   localparam int M800_H_FP     = 40;
   localparam int M800_H_SYNC   = 128;
   localparam int M800_H_BP     = 88;
   localparam int M800_V_ACTIVE = 600;
   localparam int M800_V_FP     = 1;
   localparam int M800_V_SYNC   = 4;
   localparam int M800_V_BP     = 23;
   localparam int M800_HS_POL   = 1;
   localparam int M800_VS_POL   = 1;

   // Bits needed to hold a counter running 0..n-1 (never less than 1).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // First x coordinate of bar k, i.e. smallest x with (x*BARS)/h_active >= k.
   function automatic int bar_edge(input int k, input int h_active);
      return (k * h_active + PATTERN_BARS - 1) / PATTERN_BARS;
   endfunction

endpackage

// File: rtl/vga_pix_strobe.sv
// vga_pix_strobe: divides the system clock into a one-cycle pixel strobe.
// The divider restarts from 0 while en is low so the first strobe after
// enable (or reset release) lands exactly CLK_DIV cycles later.
module vga_pix_strobe
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic strobe
);

   generate
      if (CLK_DIV <= 1) begin : g_bypass
         assign strobe = 1'b1;
      end else begin : g_div
         localparam int DW = cnt_width(CLK_DIV);
         localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

         logic [DW-1:0] div_cnt;

         // Free-running 0..CLK_DIV-1 counter, held at 0 while disabled.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               div_cnt <= '0;
            end else if (!en || (div_cnt == DIV_LAST)) begin
               div_cnt <= '0;
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
         end

         assign strobe = (div_cnt == DIV_LAST);
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen_param.sv
// vga_timing_gen_param: parametrised VGA raster engine.
// Counters advance on the pixel strobe; the request stage publishes the
// coordinate of each active pixel, and the output stage registers the
// returned colour together with the delayed syncs one pixel period later.
// Optional build macro VGA_TEST_PATTERN_EN adds pattern_sel and an internal
// 8-bar colour generator.
module vga_timing_gen_param
   import vga_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int COLOR_W  = DEFAULT_COLOR_W,
   parameter int H_ACTIVE = M640_H_ACTIVE,
   parameter int H_FP     = M640_H_FP,
   parameter int H_SYNC   = M640_H_SYNC,
   parameter int H_BP     = M640_H_BP,
   parameter int V_ACTIVE = M640_V_ACTIVE,
   parameter int V_FP     = M640_V_FP,
   parameter int V_SYNC   = M640_V_SYNC,
   parameter int V_BP     = M640_V_BP,
   parameter int HS_POL   = M640_HS_POL,
   parameter int VS_POL   = M640_VS_POL
) (
   input  logic                              CLK,
   input  logic                              RST_BTN,
   input  logic                              en,
   input  logic [RGB_CHANNELS*COLOR_W-1:0]   pix_rgb_i,
`ifdef VGA_TEST_PATTERN_EN
   input  logic                              pattern_sel,
`endif
   output logic                              pix_req,
   output logic [cnt_width(H_ACTIVE)-1:0]    pix_x,
   output logic [cnt_width(V_ACTIVE)-1:0]    pix_y,
   output logic                              line_start,
   output logic                              frame_start,
   output logic                              VGA_HS_O,
   output logic                              VGA_VS_O,
   output logic [COLOR_W-1:0]                VGA_R,
   output logic [COLOR_W-1:0]                VGA_G,
   output logic [COLOR_W-1:0]                VGA_B
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_width(H_TOTAL);
   localparam int VW      = cnt_width(V_TOTAL);
   localparam int XW      = cnt_width(H_ACTIVE);
   localparam int YW      = cnt_width(V_ACTIVE);

   localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic          HS_ON     = 1'(HS_POL);
   localparam logic          VS_ON     = 1'(VS_POL);

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_t;

   logic          strobe;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          active;
   logic          hs_act;
   logic          vs_act;
   logic          active_d;
   logic          hs_act_d;
   logic          vs_act_d;
   rgb_t          src_rgb;

   vga_pix_strobe #(
      .CLK_DIV (CLK_DIV)
   ) u_strobe (
      .clk    (CLK),
      .rst_n  (RST_BTN),
      .en     (en),
      .strobe (strobe)
   );

   // Raster counters: h wraps per line, v steps on the h wrap so vsync edges
   // always coincide with a line boundary.
   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (strobe) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Region decode on the current counter values.
   always_comb begin
      active = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
      hs_act = (h_cnt >= HS_START) && (h_cnt <= HS_END);
      vs_act = (v_cnt >= VS_START) && (v_cnt <= VS_END);
   end

   // Request stage: one-CLK pulses on the strobe, coordinates held between
   // strobes, region bits delayed for the output stage.
   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         pix_req     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         active_d    <= 1'b0;
         hs_act_d    <= 1'b0;
         vs_act_d    <= 1'b0;
      end else if (!en) begin
         pix_req     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         active_d    <= 1'b0;
         hs_act_d    <= 1'b0;
         vs_act_d    <= 1'b0;
      end else begin
         pix_req     <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (strobe) begin
            pix_req     <= active;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            pix_x       <= active ? h_cnt[XW-1:0] : '0;
            pix_y       <= active ? v_cnt[YW-1:0] : '0;
            active_d    <= active;
            hs_act_d    <= hs_act;
            vs_act_d    <= vs_act;
         end
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar_idx;
   rgb_t       bar_rgb;

   // Colour source: 8 vertical bars keyed off the requested x (still held
   // on pix_x at the output strobe), or the external pixel source.
   always_comb begin
      bar_idx = '0;
      for (int k = 1; k < PATTERN_BARS; k++) begin
         if (pix_x >= XW'(bar_edge(k, H_ACTIVE))) begin
            bar_idx = 3'(k);
         end
      end
      bar_rgb.r = {COLOR_W{bar_idx[2]}};
      bar_rgb.g = {COLOR_W{bar_idx[1]}};
      bar_rgb.b = {COLOR_W{bar_idx[0]}};
      src_rgb   = pattern_sel ? bar_rgb : rgb_t'(pix_rgb_i);
   end
`else
   // Colour source: external pixel data only.
   always_comb begin
      src_rgb = rgb_t'(pix_rgb_i);
   end
`endif

   // Output stage: colour and syncs update together one pixel period after
   // the request; blanking forces colour to 0.
   always_ff @(posedge CLK or negedge RST_BTN) begin
      if (!RST_BTN) begin
         VGA_R    <= '0;
         VGA_G    <= '0;
         VGA_B    <= '0;
         VGA_HS_O <= ~HS_ON;
         VGA_VS_O <= ~VS_ON;
      end else if (!en) begin
         VGA_R    <= '0;
         VGA_G    <= '0;
         VGA_B    <= '0;
         VGA_HS_O <= ~HS_ON;
         VGA_VS_O <= ~VS_ON;
      end else if (strobe) begin
         VGA_R    <= active_d ? src_rgb.r : '0;
         VGA_G    <= active_d ? src_rgb.g : '0;
         VGA_B    <= active_d ? src_rgb.b : '0;
         VGA_HS_O <= hs_act_d ? HS_ON : ~HS_ON;
         VGA_VS_O <= vs_act_d ? VS_ON : ~VS_ON;
      end
   end

endmodule
